// File: rtl/multi_port_switch_state_machine_if.sv
// multi_port_switch_state_machine_if: cfg routing bundle; master = request source and port models, slave = switch FSM
interface multi_port_switch_state_machine_if #(
  parameter int NUM_DSP = 2,
  parameter int SEL_W   = 4
);
  logic                   usp_user_reset_dsp_domain;
  logic                   usp_bus_num_rdy;
  logic [SEL_W-1:0]       routing_select;
  logic                   routing_unsupported_req;
  logic [3:0]             routing_req_type;
  logic                   dsp_m_axis_rc_tready_combined;
  logic [9:0]             rq_cfg_mgmt_addr;
  logic [15:0]            rq_cfg_mgmt_function_number;
  logic                   rq_cfg_mgmt_write;
  logic [31:0]            rq_cfg_mgmt_write_data;
  logic [3:0]             rq_cfg_mgmt_byte_enable;
  logic                   rq_cfg_mgmt_read;
  logic                   rq_cfg_mgmt_debug_access;
  logic [NUM_DSP*10-1:0]  cfg_mgmt_addr;
  logic [NUM_DSP*16-1:0]  cfg_mgmt_function_number;
  logic [NUM_DSP-1:0]     cfg_mgmt_write;
  logic [NUM_DSP*32-1:0]  cfg_mgmt_write_data;
  logic [NUM_DSP*4-1:0]   cfg_mgmt_byte_enable;
  logic [NUM_DSP-1:0]     cfg_mgmt_read;
  logic [NUM_DSP-1:0]     cfg_mgmt_debug_access;
  logic [NUM_DSP*32-1:0]  cfg_mgmt_read_data;
  logic [NUM_DSP-1:0]     cfg_mgmt_read_write_done;
  logic [31:0]            cpl_data_DW_cfgrd_t1;
  logic                   cpl_timeout;
  logic [2:0]             cpl_port;
  logic                   switch_usp_cq_accept;
  logic                   switch_dsp_rc_accept;
  logic                   switch_send_cfg_completion;
  modport master (
    output usp_user_reset_dsp_domain, usp_bus_num_rdy, routing_select, routing_unsupported_req,
           routing_req_type, dsp_m_axis_rc_tready_combined, rq_cfg_mgmt_addr,
           rq_cfg_mgmt_function_number, rq_cfg_mgmt_write, rq_cfg_mgmt_write_data,
           rq_cfg_mgmt_byte_enable, rq_cfg_mgmt_read, rq_cfg_mgmt_debug_access,
           cfg_mgmt_read_data, cfg_mgmt_read_write_done,
    input  cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write, cfg_mgmt_write_data,
           cfg_mgmt_byte_enable, cfg_mgmt_read, cfg_mgmt_debug_access, cpl_data_DW_cfgrd_t1,
           cpl_timeout, cpl_port, switch_usp_cq_accept, switch_dsp_rc_accept,
           switch_send_cfg_completion
  );
  modport slave (
    input  usp_user_reset_dsp_domain, usp_bus_num_rdy, routing_select, routing_unsupported_req,
           routing_req_type, dsp_m_axis_rc_tready_combined, rq_cfg_mgmt_addr,
           rq_cfg_mgmt_function_number, rq_cfg_mgmt_write, rq_cfg_mgmt_write_data,
           rq_cfg_mgmt_byte_enable, rq_cfg_mgmt_read, rq_cfg_mgmt_debug_access,
           cfg_mgmt_read_data, cfg_mgmt_read_write_done,
    output cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write, cfg_mgmt_write_data,
           cfg_mgmt_byte_enable, cfg_mgmt_read, cfg_mgmt_debug_access, cpl_data_DW_cfgrd_t1,
           cpl_timeout, cpl_port, switch_usp_cq_accept, switch_dsp_rc_accept,
           switch_send_cfg_completion
  );
endinterface

// File: rtl/multi_port_switch_state_machine.sv
// multi_port_switch_state_machine: routes a cfg request to one of NUM_DSP cfg_mgmt ports with timeout; ports: dsp_user_clk, sys_reset_n, bus (slave modport)
module multi_port_switch_state_machine #(
  parameter int NUM_DSP     = 2,
  parameter int SEL_W       = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                                dsp_user_clk,
  input  logic                                sys_reset_n,
  multi_port_switch_state_machine_if.slave    bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, SWITCHING, WAIT_CFG_DATA} state_t;
  state_t          r_state;
  logic [2:0]      r_tgt;
  logic [2:0]      r_cpl_port;
  logic            r_cpl_unsent;
  logic            r_cpl_timeout;
  logic [31:0]     r_cpl_data;
  logic [TW-1:0]   r_tmo_cnt;
  logic            w_sw;
  logic            w_wait;
  logic            w_tready;
  logic            w_start;
  logic            w_done_sel;
  logic            w_done;
  logic            w_tmo;
  logic            w_unsup_send;
  logic            w_cpl_unsent_nxt;
  logic [31:0]     w_rd_sel;
  assign w_sw     = r_state == SWITCHING;
  assign w_wait   = r_state == WAIT_CFG_DATA;
  assign w_tready = bus.dsp_m_axis_rc_tready_combined;
  assign w_start  = w_sw && bus.routing_select != '0 && bus.routing_select <= SEL_W'(NUM_DSP) &&
                    !r_cpl_unsent && !bus.routing_unsupported_req;
  assign w_done   = w_wait && w_done_sel;
  assign w_tmo    = w_wait && !w_done_sel && r_tmo_cnt == TW'(TIMEOUT_CYC - 1);
  assign w_unsup_send = bus.routing_unsupported_req && bus.routing_req_type != 4'b0001 &&
                        bus.routing_req_type <= 4'b1011;
  assign w_cpl_unsent_nxt = bus.usp_user_reset_dsp_domain ? 1'b0 :
                            w_start ? 1'b1 :
                            (w_sw && w_tready) ? 1'b0 : r_cpl_unsent;
  assign bus.switch_usp_cq_accept       = ~w_cpl_unsent_nxt;
  assign bus.switch_dsp_rc_accept       = w_sw ? (~r_cpl_unsent & w_tready) : w_tready;
  assign bus.switch_send_cfg_completion = w_sw & ((r_cpl_unsent & w_tready) | w_unsup_send);
  assign bus.cpl_data_DW_cfgrd_t1       = r_cpl_data;
  assign bus.cpl_timeout                = r_cpl_timeout;
  assign bus.cpl_port                   = r_cpl_port;
  always_comb begin
    w_rd_sel = '0;
    w_done_sel = 1'b0;
    bus.cfg_mgmt_addr = '0;
    bus.cfg_mgmt_function_number = '0;
    bus.cfg_mgmt_write = '0;
    bus.cfg_mgmt_write_data = '0;
    bus.cfg_mgmt_byte_enable = '0;
    bus.cfg_mgmt_read = '0;
    bus.cfg_mgmt_debug_access = '0;
    for (int p = 0; p < NUM_DSP; p++) begin
      if (r_tgt == 3'(p)) begin
        w_rd_sel = bus.cfg_mgmt_read_data[p*32 +: 32];
        w_done_sel = bus.cfg_mgmt_read_write_done[p];
      end
      if (w_wait && r_tgt == 3'(p)) begin
        bus.cfg_mgmt_addr[p*10 +: 10] = bus.rq_cfg_mgmt_addr;
        bus.cfg_mgmt_function_number[p*16 +: 16] = bus.rq_cfg_mgmt_function_number;
        bus.cfg_mgmt_write[p] = bus.rq_cfg_mgmt_write;
        bus.cfg_mgmt_write_data[p*32 +: 32] = bus.rq_cfg_mgmt_write_data;
        bus.cfg_mgmt_byte_enable[p*4 +: 4] = bus.rq_cfg_mgmt_byte_enable;
        bus.cfg_mgmt_read[p] = bus.rq_cfg_mgmt_read;
        bus.cfg_mgmt_debug_access[p] = bus.rq_cfg_mgmt_debug_access;
      end
    end
  end
  always_ff @(posedge dsp_user_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_state <= IDLE;
      r_tgt <= '0;
      r_cpl_unsent <= 1'b0;
      r_cpl_data <= '0;
      r_cpl_timeout <= 1'b0;
      r_cpl_port <= '0;
      r_tmo_cnt <= '0;
    end else if (bus.usp_user_reset_dsp_domain) begin
      r_state <= IDLE;
      r_tgt <= '0;
      r_cpl_unsent <= 1'b0;
      r_cpl_data <= '0;
      r_cpl_timeout <= 1'b0;
      r_cpl_port <= '0;
      r_tmo_cnt <= '0;
    end else begin
      r_cpl_unsent <= w_cpl_unsent_nxt;
      case (r_state)
        IDLE: if (bus.usp_bus_num_rdy) r_state <= SWITCHING;
        SWITCHING:
          if (w_start) begin
            r_state <= WAIT_CFG_DATA;
            r_tgt <= 3'(bus.routing_select - SEL_W'(1));
            r_tmo_cnt <= '0;
          end else if (r_cpl_unsent && !w_tready) r_cpl_data <= '0;
        WAIT_CFG_DATA:
          if (w_done || w_tmo) begin
            r_state <= SWITCHING;
            r_cpl_data <= w_done ? w_rd_sel : 32'hFFFF_FFFF;
            r_cpl_timeout <= !w_done;
            r_cpl_port <= r_tgt;
          end else r_tmo_cnt <= r_tmo_cnt + TW'(1);
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_port_switch_state_machine.sv
// tb_multi_port_switch_state_machine: randomized scoreboard bench for the cfg routing switch
module tb_multi_port_switch_state_machine;
  localparam int ND = 2;
  localparam int SW = 4;
  localparam int TC = 8;
  typedef struct packed {logic unsup; logic [31:0] data; logic tmo; logic [2:0] port;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t sb[$];
  multi_port_switch_state_machine_if #(.NUM_DSP(ND), .SEL_W(SW)) bus();
  multi_port_switch_state_machine #(.NUM_DSP(ND), .SEL_W(SW), .TIMEOUT_CYC(TC)) dut (
    .dsp_user_clk(clk),
    .sys_reset_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rand_rq();
    bus.rq_cfg_mgmt_addr = 10'($urandom);
    bus.rq_cfg_mgmt_function_number = 16'($urandom);
    bus.rq_cfg_mgmt_write = 1'($urandom);
    bus.rq_cfg_mgmt_write_data = $urandom;
    bus.rq_cfg_mgmt_byte_enable = 4'($urandom);
    bus.rq_cfg_mgmt_read = 1'($urandom);
    bus.rq_cfg_mgmt_debug_access = 1'($urandom);
  endtask
  task automatic chk_slices(input int tgt);
    logic [63:0] ea = '0, ef = '0, ew = '0, ed = '0, eb = '0, er = '0, eg = '0;
    if (tgt >= 0) begin
      ea[tgt*10 +: 10] = bus.rq_cfg_mgmt_addr;
      ef[tgt*16 +: 16] = bus.rq_cfg_mgmt_function_number;
      ew[tgt] = bus.rq_cfg_mgmt_write;
      ed[tgt*32 +: 32] = bus.rq_cfg_mgmt_write_data;
      eb[tgt*4 +: 4] = bus.rq_cfg_mgmt_byte_enable;
      er[tgt] = bus.rq_cfg_mgmt_read;
      eg[tgt] = bus.rq_cfg_mgmt_debug_access;
    end
    check("cfg_addr", 64'(bus.cfg_mgmt_addr), ea);
    check("cfg_fn", 64'(bus.cfg_mgmt_function_number), ef);
    check("cfg_write", 64'(bus.cfg_mgmt_write), ew);
    check("cfg_wdata", 64'(bus.cfg_mgmt_write_data), ed);
    check("cfg_be", 64'(bus.cfg_mgmt_byte_enable), eb);
    check("cfg_read", 64'(bus.cfg_mgmt_read), er);
    check("cfg_debug", 64'(bus.cfg_mgmt_debug_access), eg);
  endtask
  // d >= TC means the port never answers; h = cycles tready is held low after completion
  task automatic do_req(input int port, input int d, input logic [31:0] data, input int h);
    logic [31:0] cpl;
    tick();
    rand_rq();
    bus.routing_select = SW'(port + 1);
    bus.dsp_m_axis_rc_tready_combined = 1'b1;
    @(negedge clk);
    chk_slices(-1);
    check("cq_accept_on_accept", 64'(bus.switch_usp_cq_accept), 0);
    tick();
    bus.routing_select = '0;
    for (int k = 0; k < TC; k++) begin
      for (int q = 0; q < ND; q++) begin
        bus.cfg_mgmt_read_data[q*32 +: 32] = (q == port) ? data : $urandom;
        bus.cfg_mgmt_read_write_done[q] = (q == port) ? (k == d) : 1'($urandom);
      end
      @(negedge clk);
      chk_slices(port);
      check("cq_accept_busy", 64'(bus.switch_usp_cq_accept), 0);
      tick();
      if (k == d) break;
    end
    bus.cfg_mgmt_read_write_done = '0;
    cpl = (d < TC) ? data : 32'hFFFF_FFFF;
    sb.push_back({1'b0, (h > 0) ? 32'h0 : cpl, d >= TC, 3'(port)});
    bus.dsp_m_axis_rc_tready_combined = (h == 0);
    @(negedge clk);
    check("cpl_data_latched", 64'(bus.cpl_data_DW_cfgrd_t1), 64'(cpl));
    check("cpl_timeout_latched", 64'(bus.cpl_timeout), 64'(d >= TC));
    check("cpl_port_latched", 64'(bus.cpl_port), 64'(port));
    chk_slices(-1);
    for (int i = 0; i < h; i++) begin
      if (i > 0) @(negedge clk);
      check("hold_rc_accept", 64'(bus.switch_dsp_rc_accept), 0);
      check("hold_send", 64'(bus.switch_send_cfg_completion), 0);
      check("hold_cq_accept", 64'(bus.switch_usp_cq_accept), 0);
      tick();
      bus.dsp_m_axis_rc_tready_combined = (i == h - 1);
    end
    if (h > 0) @(negedge clk);
    check("send_pulse", 64'(bus.switch_send_cfg_completion), 1);
    tick();
    @(negedge clk);
    check("send_single", 64'(bus.switch_send_cfg_completion), 0);
    check("cq_accept_after", 64'(bus.switch_usp_cq_accept), 1);
  endtask
  task automatic do_unsup(input logic [3:0] t);
    logic exp_send;
    tick();
    rand_rq();
    exp_send = (t != 4'b0001) && (t <= 4'b1011);
    bus.routing_unsupported_req = 1'b1;
    bus.routing_req_type = t;
    bus.routing_select = SW'(1);
    bus.dsp_m_axis_rc_tready_combined = 1'b1;
    if (exp_send) sb.push_back({1'b1, 32'h0, 1'b0, 3'h0});
    @(negedge clk);
    check("unsup_send", 64'(bus.switch_send_cfg_completion), 64'(exp_send));
    chk_slices(-1);
    tick();
    bus.routing_unsupported_req = 1'b0;
    bus.routing_select = '0;
    @(negedge clk);
    chk_slices(-1);
  endtask
  task automatic do_bad_sel(input logic [SW-1:0] s);
    tick();
    rand_rq();
    bus.routing_select = s;
    @(negedge clk);
    chk_slices(-1);
    check("bad_sel_cq_accept", 64'(bus.switch_usp_cq_accept), 1);
    tick();
    @(negedge clk);
    chk_slices(-1);
    bus.routing_select = '0;
  endtask
  task automatic do_soft_reset();
    tick();
    rand_rq();
    bus.routing_select = SW'(1);
    tick();
    bus.routing_select = '0;
    bus.cfg_mgmt_read_write_done = '0;
    @(negedge clk);
    chk_slices(0);
    tick();
    bus.usp_user_reset_dsp_domain = 1'b1;
    @(negedge clk);
    check("soft_rst_cq_accept", 64'(bus.switch_usp_cq_accept), 1);
    tick();
    bus.usp_user_reset_dsp_domain = 1'b0;
    @(negedge clk);
    chk_slices(-1);
    check("soft_rst_cpl_data", 64'(bus.cpl_data_DW_cfgrd_t1), 0);
    check("soft_rst_cpl_timeout", 64'(bus.cpl_timeout), 0);
    check("soft_rst_cpl_port", 64'(bus.cpl_port), 0);
    bus.cfg_mgmt_read_data[31:0] = 32'h1234_5678;
    bus.cfg_mgmt_read_write_done[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk_slices(-1);
      check("late_done_send", 64'(bus.switch_send_cfg_completion), 0);
    end
    bus.cfg_mgmt_read_write_done = '0;
  endtask
  always @(negedge clk) begin
    if (bus.switch_send_cfg_completion) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_send: got send=1 expected no send at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.unsup) check("unsup_rc_accept", 64'(bus.switch_dsp_rc_accept), 1);
        else begin
          check("sb_cpl_data", 64'(bus.cpl_data_DW_cfgrd_t1), 64'(e.data));
          check("sb_cpl_timeout", 64'(bus.cpl_timeout), 64'(e.tmo));
          check("sb_cpl_port", 64'(bus.cpl_port), 64'(e.port));
          check("sb_rc_accept", 64'(bus.switch_dsp_rc_accept), 0);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.usp_user_reset_dsp_domain = 1'b0;
    bus.usp_bus_num_rdy = 1'b0;
    bus.routing_select = '0;
    bus.routing_unsupported_req = 1'b0;
    bus.routing_req_type = '0;
    bus.dsp_m_axis_rc_tready_combined = 1'b0;
    bus.cfg_mgmt_read_data = '0;
    bus.cfg_mgmt_read_write_done = '0;
    rand_rq();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cq_accept", 64'(bus.switch_usp_cq_accept), 1);
    check("rst_rc_accept_lo", 64'(bus.switch_dsp_rc_accept), 0);
    check("rst_send", 64'(bus.switch_send_cfg_completion), 0);
    check("rst_cpl_data", 64'(bus.cpl_data_DW_cfgrd_t1), 0);
    check("rst_cpl_timeout", 64'(bus.cpl_timeout), 0);
    check("rst_cpl_port", 64'(bus.cpl_port), 0);
    chk_slices(-1);
    bus.dsp_m_axis_rc_tready_combined = 1'b1;
    #1;
    check("rst_rc_accept_hi", 64'(bus.switch_dsp_rc_accept), 1);
    tick();
    rst_n = 1'b1;
    bus.usp_bus_num_rdy = 1'b1;
    do_req(1, 2, 32'hDEAD_BEEF, 0);
    do_req(0, 99, 32'h0BAD_F00D, 0);
    do_req(1, 1, 32'hCAFE_0001, 4);
    do_unsup(4'b0000);
    do_unsup(4'b0001);
    do_unsup(4'b1100);
    do_soft_reset();
    do_bad_sel('0);
    do_bad_sel(SW'(ND + 1));
    do_req(0, TC - 1, 32'hA5A5_5A5A, 0);
    bus.usp_bus_num_rdy = 1'b0;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 5))
        0: do_unsup(4'($urandom));
        1: do_bad_sel(SW'($urandom_range(ND + 1, (1 << SW) - 1)));
        default: do_req($urandom_range(0, ND - 1), $urandom_range(0, TC + 1), $urandom,
                        ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0);
      endcase
    end
    tick();
    check("scoreboard_drained", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
